decode_stage_pipe: RTL and testbench

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

---
 rtl/decode_pkg.sv | 68 ++++++
 rtl/decode_regfile.sv | 50 +++++
 rtl/decode_stage_pipe.sv | 250 +++++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// =============================================================================
// Module      : decode_pkg
// Description : Shared opcode, ALU-operation and immediate-type encodings for
//               the decode stage, plus the ALU-op selection helper.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package decode_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IALU   = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLTU = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_SRL  = 4'd10
    } aluop_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4
    } imm_e;

    typedef struct packed {
        aluop_e aluop;
        logic   alusrc;
        logic   pc_sel;
        logic   wb;
        logic   mem_read;
        logic   mem_write;
        logic   illegal;
    } ctrl_t;

    // instr[30] picks SUB only for register-register ops; it always picks SRA.
    function automatic aluop_e alu_from_f3(input logic [2:0] f3,
                                           input logic       bit30,
                                           input logic       is_reg);
        case (f3)
            3'd0:    return (is_reg && bit30) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return bit30 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_regfile.sv
// =============================================================================
// Module      : decode_regfile
// Description : NREG x XLEN register file, two async read ports, one write
//               port, x0 hardwired to zero, same-cycle write-to-read bypass.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module decode_regfile #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [RW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RW-1:0]   raddr1,
    input  logic [RW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage_pipe.sv
// =============================================================================
// Module      : decode_stage_pipe
// Description : RV-style instruction decode stage with hazard detection,
//               early branch resolution and a registered ID/EX output.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    input  logic            ex_ready,
    input  logic            wb_en,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            exmem_wb,
    input  logic            exmem_mem_read,
    input  logic [RW-1:0]   exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            if_flush,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_pc,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [RW-1:0]   idex_rs1,
    output logic [RW-1:0]   idex_rs2,
    output logic [RW-1:0]   idex_rd,
    output logic [XLEN-1:0] idex_imm,
    output logic [XLEN-1:0] idex_rdata1,
    output logic [XLEN-1:0] idex_rdata2,
    output logic [3:0]      idex_aluop,
    output logic [2:0]      idex_memop,
    output logic            idex_alusrc,
    output logic            idex_pc_sel,
    output logic            idex_wb,
    output logic            idex_mem_read,
    output logic            idex_mem_write,
    output logic            idex_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      rd_f, rs1_f, rs2_f;
    logic [RW-1:0]   rd_idx, rs1_idx, rs2_idx;
    ctrl_t           ctrl;
    imm_e            imm_sel;
    logic            use1, use2, is_branch, is_lui, reg_oor;
    logic [XLEN-1:0] imm, rdata1, rdata2, op1, op2;
    logic            hit_idex1, hit_idex2, hit_mem1, hit_mem2;
    logic            load_use, br_hazard, stall, accept, cond, taken;

    assign opcode  = if_instr[6:0];
    assign f3      = if_instr[14:12];
    assign rd_f    = if_instr[11:7];
    assign rs1_f   = if_instr[19:15];
    assign rs2_f   = if_instr[24:20];
    assign rd_idx  = rd_f[RW-1:0];
    assign rs1_idx = rs1_f[RW-1:0];
    assign rs2_idx = rs2_f[RW-1:0];

    always_comb begin
        ctrl       = '0;
        ctrl.aluop = ALU_ADD;
        imm_sel    = IMM_NONE;
        use1       = 1'b0;
        use2       = 1'b0;
        is_branch  = 1'b0;
        is_lui     = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.aluop = alu_from_f3(f3, if_instr[30], 1'b1);
                ctrl.wb    = 1'b1;
                use1       = 1'b1;
                use2       = 1'b1;
            end
            OP_IALU: begin
                ctrl.aluop  = alu_from_f3(f3, if_instr[30], 1'b0);
                ctrl.alusrc = 1'b1;
                ctrl.wb     = 1'b1;
                use1        = 1'b1;
                imm_sel     = IMM_I;
            end
            OP_LOAD: begin
                ctrl.alusrc   = 1'b1;
                ctrl.wb       = 1'b1;
                ctrl.mem_read = 1'b1;
                use1          = 1'b1;
                imm_sel       = IMM_I;
            end
            OP_STORE: begin
                ctrl.alusrc    = 1'b1;
                ctrl.mem_write = 1'b1;
                use1           = 1'b1;
                use2           = 1'b1;
                imm_sel        = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.aluop   = ALU_SUB;
                ctrl.illegal = (f3[2:1] == 2'b01);
                use1         = 1'b1;
                use2         = 1'b1;
                is_branch    = 1'b1;
                imm_sel      = IMM_B;
            end
            OP_LUI: begin
                ctrl.alusrc = 1'b1;
                ctrl.wb     = 1'b1;
                is_lui      = 1'b1;
                imm_sel     = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.alusrc = 1'b1;
                ctrl.pc_sel = 1'b1;
                ctrl.wb     = 1'b1;
                imm_sel     = IMM_U;
            end
            default: ctrl.illegal = 1'b1;
        endcase

        // Register fields beyond the architectural file are only possible when NREG < 32.
        reg_oor = (use1 && (32'(rs1_f) >= NREG)) ||
                  (use2 && (32'(rs2_f) >= NREG)) ||
                  (ctrl.wb && (32'(rd_f) >= NREG));
        if (reg_oor) begin
            ctrl.illegal = 1'b1;
        end

        if (ctrl.illegal) begin
            ctrl.wb        = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            use1           = 1'b0;
            use2           = 1'b0;
            is_branch      = 1'b0;
        end
    end

    always_comb begin
        case (imm_sel)
            IMM_I:   imm = XLEN'($signed(if_instr[31:20]));
            IMM_S:   imm = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
            IMM_B:   imm = XLEN'($signed({if_instr[31], if_instr[7], if_instr[30:25],
                                          if_instr[11:8], 1'b0}));
            IMM_U:   imm = XLEN'($signed({if_instr[31:12], 12'b0}));
            default: imm = '0;
        endcase
    end

    decode_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_en && !reset),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1_idx),
        .raddr2 (rs2_idx),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    assign hit_idex1 = use1 && (rs1_idx != '0) && (rs1_idx == idex_rd);
    assign hit_idex2 = use2 && (rs2_idx != '0) && (rs2_idx == idex_rd);
    assign hit_mem1  = use1 && (rs1_idx != '0) && (rs1_idx == exmem_rd);
    assign hit_mem2  = use2 && (rs2_idx != '0) && (rs2_idx == exmem_rd);

    assign load_use  = idex_valid && idex_mem_read && (hit_idex1 || hit_idex2);
    assign br_hazard = is_branch &&
                       ((idex_valid && idex_wb && (hit_idex1 || hit_idex2)) ||
                        (exmem_wb && exmem_mem_read && (hit_mem1 || hit_mem2)));
    assign stall     = if_valid && !ctrl.illegal && (load_use || br_hazard);
    assign accept    = ex_ready && !stall && if_valid;

    // Branches resolve here, so ALU results still in EX/MEM must be forwarded.
    assign op1 = (exmem_wb && !exmem_mem_read && hit_mem1) ? exmem_result : rdata1;
    assign op2 = (exmem_wb && !exmem_mem_read && hit_mem2) ? exmem_result : rdata2;

    always_comb begin
        case (f3)
            3'd0:    cond = (op1 == op2);
            3'd1:    cond = (op1 != op2);
            3'd4:    cond = ($signed(op1) <  $signed(op2));
            3'd5:    cond = ($signed(op1) >= $signed(op2));
            3'd6:    cond = (op1 <  op2);
            3'd7:    cond = (op1 >= op2);
            default: cond = 1'b0;
        endcase
    end

    assign taken        = accept && is_branch && cond;
    assign pc_write     = !reset && ex_ready && !stall;
    assign ifid_write   = !reset && ex_ready && !stall;
    assign branch_taken = !reset && taken;
    assign if_flush     = reset || taken;
    assign branch_pc    = if_pc + imm;

    always_ff @(posedge clk) begin
        if (reset || (ex_ready && !accept)) begin
            idex_valid     <= 1'b0;
            idex_pc        <= '0;
            idex_rs1       <= '0;
            idex_rs2       <= '0;
            idex_rd        <= '0;
            idex_imm       <= '0;
            idex_rdata1    <= '0;
            idex_rdata2    <= '0;
            idex_aluop     <= '0;
            idex_memop     <= '0;
            idex_alusrc    <= 1'b0;
            idex_pc_sel    <= 1'b0;
            idex_wb        <= 1'b0;
            idex_mem_read  <= 1'b0;
            idex_mem_write <= 1'b0;
            idex_illegal   <= 1'b0;
        end else if (ex_ready) begin
            idex_valid     <= 1'b1;
            idex_pc        <= if_pc;
            idex_rs1       <= is_lui ? '0 : rs1_idx;
            idex_rs2       <= rs2_idx;
            idex_rd        <= rd_idx;
            idex_imm       <= imm;
            idex_rdata1    <= rdata1;
            idex_rdata2    <= rdata2;
            idex_aluop     <= ctrl.aluop;
            idex_memop     <= f3;
            idex_alusrc    <= ctrl.alusrc;
            idex_pc_sel    <= ctrl.pc_sel;
            idex_wb        <= ctrl.wb;
            idex_mem_read  <= ctrl.mem_read;
            idex_mem_write <= ctrl.mem_write;
            idex_illegal   <= ctrl.illegal;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
// =============================================================================
// Module      : tb_decode_stage_pipe
// Description : Directed self-checking bench for decode_stage_pipe.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        ex_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exmem_wb;
    logic        exmem_mem_read;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;

    logic        pc_write, ifid_write, if_flush, branch_taken;
    logic [31:0] branch_pc, idex_pc, idex_imm, idex_rdata1, idex_rdata2;
    logic        idex_valid, idex_alusrc, idex_pc_sel, idex_wb;
    logic        idex_mem_read, idex_mem_write, idex_illegal;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic [3:0]  idex_aluop;
    logic [2:0]  idex_memop;

    logic        s_pc_write, s_ifid_write, s_if_flush, s_branch_taken;
    logic [31:0] s_branch_pc, s_idex_pc, s_idex_imm, s_idex_rdata1, s_idex_rdata2;
    logic        s_idex_valid, s_idex_alusrc, s_idex_pc_sel, s_idex_wb;
    logic        s_idex_mem_read, s_idex_mem_write, s_idex_illegal;
    logic [3:0]  s_idex_rs1, s_idex_rs2, s_idex_rd;
    logic [3:0]  s_idex_aluop;
    logic [2:0]  s_idex_memop;
    logic [3:0]  wb_rd16, exmem_rd16;

    int checks = 0;
    int errors = 0;

    assign wb_rd16    = wb_rd[3:0];
    assign exmem_rd16 = exmem_rd[3:0];

    always #5 clk = ~clk;

    decode_stage_pipe #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .ex_ready(ex_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .exmem_wb(exmem_wb), .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .pc_write(pc_write), .ifid_write(ifid_write),
        .if_flush(if_flush), .branch_taken(branch_taken), .branch_pc(branch_pc),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
        .idex_rd(idex_rd), .idex_imm(idex_imm), .idex_rdata1(idex_rdata1),
        .idex_rdata2(idex_rdata2), .idex_aluop(idex_aluop), .idex_memop(idex_memop),
        .idex_alusrc(idex_alusrc), .idex_pc_sel(idex_pc_sel), .idex_wb(idex_wb),
        .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
        .idex_illegal(idex_illegal)
    );

    decode_stage_pipe #(.XLEN(32), .NREG(16)) dut16 (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .ex_ready(ex_ready), .wb_en(wb_en), .wb_rd(wb_rd16), .wb_data(wb_data),
        .exmem_wb(exmem_wb), .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd16),
        .exmem_result(exmem_result), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .if_flush(s_if_flush), .branch_taken(s_branch_taken), .branch_pc(s_branch_pc),
        .idex_valid(s_idex_valid), .idex_pc(s_idex_pc), .idex_rs1(s_idex_rs1),
        .idex_rs2(s_idex_rs2), .idex_rd(s_idex_rd), .idex_imm(s_idex_imm),
        .idex_rdata1(s_idex_rdata1), .idex_rdata2(s_idex_rdata2), .idex_aluop(s_idex_aluop),
        .idex_memop(s_idex_memop), .idex_alusrc(s_idex_alusrc), .idex_pc_sel(s_idex_pc_sel),
        .idex_wb(s_idex_wb), .idex_mem_read(s_idex_mem_read),
        .idex_mem_write(s_idex_mem_write), .idex_illegal(s_idex_illegal)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_valid = 1'b1; if_pc = 32'h40; ex_ready = 1'b1;
        if_instr = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write got=%0h exp=0", pc_write); end
        checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL rst_ifid_write got=%0h exp=0", ifid_write); end
        checks++; if (if_flush !== 1'b1) begin errors++; $display("FAIL rst_if_flush got=%0h exp=1", if_flush); end
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL rst_branch_taken got=%0h exp=0", branch_taken); end
        tick(); tick();
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL rst_idex_valid got=%0h exp=0", idex_valid); end
        checks++; if (idex_pc !== 32'h0) begin errors++; $display("FAIL rst_idex_pc got=%0h exp=0", idex_pc); end
        checks++; if (idex_imm !== 32'h0) begin errors++; $display("FAIL rst_idex_imm got=%0h exp=0", idex_imm); end
        checks++; if (idex_wb !== 1'b0 || idex_rd !== 5'd0 || idex_aluop !== 4'd0) begin
            errors++; $display("FAIL rst_idex_ctrl got wb=%0h rd=%0d aluop=%0d exp all 0", idex_wb, idex_rd, idex_aluop); end
        reset = 1'b0; if_valid = 1'b0;
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h10;
        if_valid = 1'b1; if_pc = 32'h100; if_instr = enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6);
        #1;
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
            errors++; $display("FAIL byp_fetch_ctl got pc_write=%0h ifid_write=%0h exp 1/1", pc_write, ifid_write); end
        checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL byp_if_flush got=%0h exp=0", if_flush); end
        tick();
        wb_en = 1'b0;
        checks++; if (idex_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got=%0h exp=1", idex_valid); end
        checks++; if (idex_rdata1 !== 32'h10) begin errors++; $display("FAIL byp_rdata1 got=%0h exp=10", idex_rdata1); end
        checks++; if (idex_rdata2 !== 32'h10) begin errors++; $display("FAIL byp_rdata2 got=%0h exp=10", idex_rdata2); end
        checks++; if (idex_pc !== 32'h100 || idex_rd !== 5'd6) begin
            errors++; $display("FAIL byp_pc_rd got pc=%0h rd=%0d exp 100/6", idex_pc, idex_rd); end
        checks++; if (idex_aluop !== 4'd2 || idex_wb !== 1'b1 || idex_alusrc !== 1'b0) begin
            errors++; $display("FAIL byp_ctrl got aluop=%0d wb=%0h alusrc=%0h exp 2/1/0", idex_aluop, idex_wb, idex_alusrc); end
    endtask

    task automatic test_alu_imm();
        if_instr = enc_r(7'h20, 5'd5, 5'd5, 3'd0, 5'd8);
        tick();
        checks++; if (idex_aluop !== 4'd3) begin errors++; $display("FAIL sub_aluop got=%0d exp=3", idex_aluop); end
        checks++; if (idex_rdata1 !== 32'h10) begin errors++; $display("FAIL stored_x5 got=%0h exp=10", idex_rdata1); end
        if_instr = enc_i(12'h403, 5'd5, 3'd5, 5'd9, 7'h13);
        tick();
        checks++; if (idex_aluop !== 4'd9 || idex_alusrc !== 1'b1) begin
            errors++; $display("FAIL srai got aluop=%0d alusrc=%0h exp 9/1", idex_aluop, idex_alusrc); end
        if_instr = {20'h12345, 5'd5, 7'h37};
        tick();
        checks++; if (idex_imm !== 32'h12345000) begin errors++; $display("FAIL lui_imm got=%0h exp=12345000", idex_imm); end
        checks++; if (idex_rs1 !== 5'd0 || idex_aluop !== 4'd2 || idex_alusrc !== 1'b1 || idex_pc_sel !== 1'b0) begin
            errors++; $display("FAIL lui_ctrl got rs1=%0d aluop=%0d alusrc=%0h pc_sel=%0h exp 0/2/1/0", idex_rs1, idex_aluop, idex_alusrc, idex_pc_sel); end
        if_instr = {20'hFFFFF, 5'd7, 7'h17};
        tick();
        checks++; if (idex_imm !== 32'hFFFFF000 || idex_pc_sel !== 1'b1) begin
            errors++; $display("FAIL auipc got imm=%0h pc_sel=%0h exp fffff000/1", idex_imm, idex_pc_sel); end
        if_instr = enc_s(12'hFFC, 5'd5, 5'd6, 3'd2);
        tick();
        checks++; if (idex_imm !== 32'hFFFFFFFC || idex_mem_write !== 1'b1 || idex_wb !== 1'b0 || idex_memop !== 3'd2) begin
            errors++; $display("FAIL store got imm=%0h mw=%0h wb=%0h memop=%0d exp fffffffc/1/0/2", idex_imm, idex_mem_write, idex_wb, idex_memop); end
        if_instr = enc_i(12'hFFD, 5'd0, 3'd0, 5'd1, 7'h13);
        tick();
        checks++; if (idex_imm !== 32'hFFFFFFFD) begin errors++; $display("FAIL addi_imm got=%0h exp=fffffffd", idex_imm); end
    endtask

    task automatic test_load_use();
        if_pc = 32'h300; if_instr = enc_i(12'd0, 5'd2, 3'd2, 5'd1, 7'h03);
        tick();
        checks++; if (idex_mem_read !== 1'b1 || idex_rd !== 5'd1 || idex_memop !== 3'd2) begin
            errors++; $display("FAIL lw_ctrl got mr=%0h rd=%0d memop=%0d exp 1/1/2", idex_mem_read, idex_rd, idex_memop); end
        if_pc = 32'h304; if_instr = enc_r(7'h00, 5'd4, 5'd1, 3'd0, 5'd3);
        #1;
        checks++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
            errors++; $display("FAIL lu_stall got pc_write=%0h ifid_write=%0h exp 0/0", pc_write, ifid_write); end
        tick();
        checks++; if (idex_valid !== 1'b0 || idex_mem_read !== 1'b0) begin
            errors++; $display("FAIL lu_bubble got valid=%0h mr=%0h exp 0/0", idex_valid, idex_mem_read); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_resume got pc_write=%0h exp=1", pc_write); end
        tick();
        checks++; if (idex_valid !== 1'b1 || idex_rd !== 5'd3 || idex_pc !== 32'h304) begin
            errors++; $display("FAIL lu_add got valid=%0h rd=%0d pc=%0h exp 1/3/304", idex_valid, idex_rd, idex_pc); end
    endtask

    task automatic test_backpressure();
        if_pc = 32'h400; if_instr = enc_i(12'd0, 5'd2, 3'd2, 5'd1, 7'h03);
        tick();
        if_pc = 32'h404; if_instr = enc_r(7'h00, 5'd4, 5'd1, 3'd0, 5'd3);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pc_write !== 1'b0 || ifid_write !== 1'b0 || branch_taken !== 1'b0) begin
                errors++; $display("FAIL bp_fetch_ctl cyc=%0d got pc_write=%0h ifid_write=%0h bt=%0h exp 0/0/0", i, pc_write, ifid_write, branch_taken); end
            tick();
            checks++; if (idex_valid !== 1'b1 || idex_mem_read !== 1'b1 || idex_pc !== 32'h400 || idex_rd !== 5'd1) begin
                errors++; $display("FAIL bp_frozen cyc=%0d got valid=%0h mr=%0h pc=%0h rd=%0d exp 1/1/400/1", i, idex_valid, idex_mem_read, idex_pc, idex_rd); end
        end
        ex_ready = 1'b1;
        tick();
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL bp_bubble got valid=%0h exp=0", idex_valid); end
        tick();
        checks++; if (idex_valid !== 1'b1 || idex_pc !== 32'h404) begin
            errors++; $display("FAIL bp_add got valid=%0h pc=%0h exp 1/404", idex_valid, idex_pc); end
    endtask

    task automatic test_branch_fwd();
        if_pc = 32'h500; if_instr = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        tick();
        if_pc = 32'h504; if_instr = enc_b(13'd16, 5'd0, 5'd1, 3'd0);
        #1;
        checks++; if (pc_write !== 1'b0 || branch_taken !== 1'b0) begin
            errors++; $display("FAIL br_stall got pc_write=%0h bt=%0h exp 0/0", pc_write, branch_taken); end
        tick();
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL br_bubble got valid=%0h exp=0", idex_valid); end
        exmem_wb = 1'b1; exmem_mem_read = 1'b0; exmem_rd = 5'd1; exmem_result = 32'd5;
        #1;
        checks++; if (pc_write !== 1'b1 || branch_taken !== 1'b0 || if_flush !== 1'b0) begin
            errors++; $display("FAIL beq_fwd got pc_write=%0h bt=%0h flush=%0h exp 1/0/0", pc_write, branch_taken, if_flush); end
        tick();
        checks++; if (idex_valid !== 1'b1 || idex_wb !== 1'b0 || idex_imm !== 32'd16) begin
            errors++; $display("FAIL beq_idex got valid=%0h wb=%0h imm=%0h exp 1/0/10", idex_valid, idex_wb, idex_imm); end
        if_pc = 32'h508; if_instr = enc_b(13'h1FF8, 5'd0, 5'd1, 3'd1);
        #1;
        checks++; if (branch_taken !== 1'b1 || if_flush !== 1'b1 || branch_pc !== 32'h500) begin
            errors++; $display("FAIL bne_taken got bt=%0h flush=%0h bpc=%0h exp 1/1/500", branch_taken, if_flush, branch_pc); end
        tick();
        checks++; if (idex_valid !== 1'b1 || idex_wb !== 1'b0 || idex_mem_read !== 1'b0 || idex_mem_write !== 1'b0) begin
            errors++; $display("FAIL bne_idex got valid=%0h wb=%0h mr=%0h mw=%0h exp 1/0/0/0", idex_valid, idex_wb, idex_mem_read, idex_mem_write); end
        exmem_mem_read = 1'b1; if_instr = enc_b(13'd16, 5'd0, 5'd1, 3'd0);
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL br_mem_stall got pc_write=%0h exp=0", pc_write); end
        exmem_wb = 1'b0; exmem_mem_read = 1'b0; exmem_rd = 5'd0;
    endtask

    task automatic test_compare();
        if_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hFFFFFFFF;
        tick();
        wb_rd = 5'd2; wb_data = 32'd1;
        tick();
        wb_en = 1'b0; if_valid = 1'b1; if_pc = 32'h600;
        if_instr = enc_b(13'd32, 5'd2, 5'd1, 3'd4);
        #1;
        checks++; if (branch_taken !== 1'b1 || branch_pc !== 32'h620) begin
            errors++; $display("FAIL blt got bt=%0h bpc=%0h exp 1/620", branch_taken, branch_pc); end
        if_instr = enc_b(13'd32, 5'd2, 5'd1, 3'd6);
        #1;
        checks++; if (branch_taken !== 1'b0 || if_flush !== 1'b0) begin
            errors++; $display("FAIL bltu got bt=%0h flush=%0h exp 0/0", branch_taken, if_flush); end
        if_instr = enc_b(13'd32, 5'd1, 5'd2, 3'd5);
        #1;
        checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL bge got bt=%0h exp=1", branch_taken); end
        if_instr = enc_b(13'd32, 5'd1, 5'd2, 3'd7);
        #1;
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bgeu got bt=%0h exp=0", branch_taken); end
        tick();
    endtask

    task automatic test_illegal();
        if_pc = 32'h700; if_instr = 32'h0000007F;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL ill_no_stall got pc_write=%0h exp=1", pc_write); end
        tick();
        checks++; if (idex_valid !== 1'b1 || idex_illegal !== 1'b1 || idex_wb !== 1'b0) begin
            errors++; $display("FAIL ill_op got valid=%0h ill=%0h wb=%0h exp 1/1/0", idex_valid, idex_illegal, idex_wb); end
        if_instr = enc_b(13'd8, 5'd2, 5'd1, 3'd2);
        tick();
        checks++; if (idex_illegal !== 1'b1) begin errors++; $display("FAIL ill_br_f3 got=%0h exp=1", idex_illegal); end
        if_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd17);
        tick();
        checks++; if (s_idex_valid !== 1'b1 || s_idex_illegal !== 1'b1 || s_idex_wb !== 1'b0) begin
            errors++; $display("FAIL ill_nreg16 got valid=%0h ill=%0h wb=%0h exp 1/1/0", s_idex_valid, s_idex_illegal, s_idex_wb); end
        checks++; if (idex_illegal !== 1'b0 || idex_wb !== 1'b1) begin
            errors++; $display("FAIL legal_nreg32 got ill=%0h wb=%0h exp 0/1", idex_illegal, idex_wb); end
    endtask

    task automatic test_reset_mid();
        if_pc = 32'h800; if_instr = enc_i(12'd0, 5'd2, 3'd2, 5'd1, 7'h03);
        tick();
        if_pc = 32'h804; if_instr = enc_r(7'h00, 5'd4, 5'd1, 3'd0, 5'd3);
        ex_ready = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL mid_stall got pc_write=%0h exp=0", pc_write); end
        reset = 1'b1; wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hAA;
        #1;
        checks++; if (if_flush !== 1'b1 || pc_write !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ctl got flush=%0h pc_write=%0h exp 1/0", if_flush, pc_write); end
        tick();
        checks++; if (idex_valid !== 1'b0 || idex_mem_read !== 1'b0 || idex_pc !== 32'h0) begin
            errors++; $display("FAIL mid_rst_idex got valid=%0h mr=%0h pc=%0h exp 0/0/0", idex_valid, idex_mem_read, idex_pc); end
        reset = 1'b0; wb_en = 1'b0; ex_ready = 1'b1;
        if_instr = enc_r(7'h00, 5'd0, 5'd9, 3'd0, 5'd10);
        tick();
        checks++; if (idex_valid !== 1'b1 || idex_rdata1 !== 32'h0) begin
            errors++; $display("FAIL mid_rst_nowrite got valid=%0h rdata1=%0h exp 1/0", idex_valid, idex_rdata1); end
        if_instr = enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd11);
        tick();
        checks++; if (idex_rdata1 !== 32'h0) begin errors++; $display("FAIL rst_clears_x5 got=%0h exp=0", idex_rdata1); end
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; ex_ready = 1'b1;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        exmem_wb = 1'b0; exmem_mem_read = 1'b0; exmem_rd = '0; exmem_result = '0;
        test_reset();
        test_bypass();
        test_alu_imm();
        test_load_use();
        test_backpressure();
        test_branch_fwd();
        test_compare();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
